multi_edge_debounce: RTL and testbench

Parametrised multi-channel input conditioner for the chronometer's push-buttons and external start/stop/lap lines. Each channel is synchronised into the `clk` domain, debounced by a stability counter, and emits registered one-cycle rise and fall pulses, a clean level, and an optional long-press pulse. The block sits between the raw pad inputs and the chronometer control FSM, and replaces the single-channel, non-debounced transition detector.

---
 rtl/multi_edge_debounce_pkg.sv | 17 +
 rtl/multi_edge_debounce_if.sv | 19 +
 rtl/edge_debounce_ch.sv | 145 ++++++++++++++
 rtl/multi_edge_debounce.sv | 32 +++
 tb/tb_multi_edge_debounce.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/multi_edge_debounce_pkg.sv
// Shared definitions for the chronometer input conditioner.
//   deb_state_e : per-channel debounce FSM encoding
//   cnt_w()     : counter width able to hold 0..n (never less than 1 bit)
package chrono_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_HIGH      = 2'b10,
    ST_WAIT_LOW  = 2'b11
  } deb_state_e;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multi_edge_debounce_if.sv
// Bundle of raw inputs and conditioned outputs for multi_edge_debounce.
//   in    : raw asynchronous pad inputs, active high
//   level : debounced level
//   rise  : one-cycle pulse on accepted 0->1
//   fall  : one-cycle pulse on accepted 1->0
//   hold  : one-cycle pulse when an accepted press lasts long enough
// master = pad / control side, slave = the conditioner.
interface multi_edge_debounce_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] in;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] hold;

  modport master (output in, input level, rise, fall, hold);
  modport slave  (input in, output level, rise, fall, hold);
endinterface

// File: rtl/edge_debounce_ch.sv
// One conditioner channel: 2-flop synchroniser, debounce FSM with stability
// counter, registered rise/fall pulses and an optional long-press pulse.
//   clk, rst_n : clock, async active-low reset
//   in         : raw asynchronous input
//   level      : accepted level
//   rise, fall : one-cycle pulses on accepted transitions
//   hold       : one-cycle pulse HOLD_CYCLES cycles after rise (0 = off)
module edge_debounce_ch
  import chrono_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int             DW     = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  D_ONE  = DW'(1);
  localparam logic [DW-1:0]  D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, s;
  deb_state_e    state, state_nx;
  logic [DW-1:0] cnt, cnt_nx;
  logic          commit_hi, commit_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= in;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rise  <= commit_hi;
      fall  <= commit_lo;
      if (commit_hi)      level <= 1'b1;
      else if (commit_lo) level <= 1'b0;
    end
  end

  // cnt counts consecutive samples opposing the accepted level; any sample
  // agreeing with it aborts the pending change without a pulse.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    commit_hi = 1'b0;
    commit_lo = 1'b0;
    case (state)
      ST_LOW: if (s) begin
        if (DEBOUNCE_CYCLES == 1) begin
          state_nx  = ST_HIGH;
          commit_hi = 1'b1;
        end else begin
          state_nx = ST_WAIT_HIGH;
          cnt_nx   = D_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s) begin
          state_nx = ST_LOW;
          cnt_nx   = '0;
        end else if (cnt == D_LAST) begin
          state_nx  = ST_HIGH;
          cnt_nx    = '0;
          commit_hi = 1'b1;
        end else begin
          cnt_nx = cnt + D_ONE;
        end
      end
      ST_HIGH: if (!s) begin
        if (DEBOUNCE_CYCLES == 1) begin
          state_nx  = ST_LOW;
          commit_lo = 1'b1;
        end else begin
          state_nx = ST_WAIT_LOW;
          cnt_nx   = D_ONE;
        end
      end
      ST_WAIT_LOW: begin
        if (s) begin
          state_nx = ST_HIGH;
          cnt_nx   = '0;
        end else if (cnt == D_LAST) begin
          state_nx  = ST_LOW;
          cnt_nx    = '0;
          commit_lo = 1'b1;
        end else begin
          cnt_nx = cnt + D_ONE;
        end
      end
      default: begin
        state_nx = ST_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  if (HOLD_CYCLES > 0) begin : g_hold
    localparam int            HW    = cnt_w(HOLD_CYCLES);
    localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES);
    logic [HW-1:0] hcnt;
    logic          pressed;

    // A bounce back into ST_HIGH from ST_WAIT_LOW keeps counting, so a
    // shaky release does not restart the long-press timer.
    assign pressed = (state == ST_HIGH) || (state == ST_WAIT_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt <= '0;
        hold <= 1'b0;
      end else begin
        hold <= 1'b0;
        if (commit_hi || commit_lo) begin
          hcnt <= '0;
        end else if (pressed && hcnt != H_MAX) begin
          // saturates at H_MAX: exactly one pulse per press
          hcnt <= hcnt + HW'(1);
          hold <= (hcnt == H_MAX - HW'(1));
        end
      end
    end
  end else begin : g_no_hold
    assign hold = 1'b0;
  end

endmodule

// File: rtl/multi_edge_debounce.sv
// Multi-channel input conditioner: NUM_CH independent edge_debounce_ch
// instances, outputs concatenated bit-per-channel onto the interface.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of multi_edge_debounce_if (in -> level/rise/fall/hold)
module multi_edge_debounce
  import chrono_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multi_edge_debounce_if.slave        bus
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (bus.in[i]),
      .level (bus.level[i]),
      .rise  (bus.rise[i]),
      .fall  (bus.fall[i]),
      .hold  (bus.hold[i])
    );
  end

endmodule

// File: tb/tb_multi_edge_debounce.sv
// Bench: DUT A (4 ch, debounce 4, hold 10) and DUT B (1 ch, debounce 1,
// no hold) share clock and reset. Channels 0..3 map to A, channel 4 to B.
// Reference model: an output flips once the last DEBOUNCE synchronised
// samples (input delayed two edges) all disagree with the accepted level;
// hold fires when the level has been high for HOLD cycles since the flip.
module tb_multi_edge_debounce;
  localparam int NA = 4, DA = 4, HA = 10, DB = 1, NT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_edge_debounce_if #(.NUM_CH(NA)) ifa();
  multi_edge_debounce_if #(.NUM_CH(1))  ifb();

  logic [NT-1:0] din = '0;
  assign ifa.in = din[3:0];
  assign ifb.in = din[4];

  multi_edge_debounce #(.NUM_CH(NA), .DEBOUNCE_CYCLES(DA), .HOLD_CYCLES(HA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  multi_edge_debounce #(.NUM_CH(1), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int deb_of(input int c); return (c < NA) ? DA : DB; endfunction
  function automatic int hold_of(input int c); return (c < NA) ? HA : 0; endfunction

  // ---------------- reference model ----------------
  logic [NT-1:0] d1, d2, m_lvl, m_rise, m_fall, m_hold;
  int run[NT], age[NT];
  logic s_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = '0; d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_hold = '0;
      for (int c = 0; c < NT; c++) begin run[c] = 0; age[c] = 0; end
    end else begin
      for (int c = 0; c < NT; c++) begin
        s_m = d2[c]; d2[c] = d1[c]; d1[c] = din[c];
        m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_hold[c] = 1'b0;
        if (m_lvl[c]) age[c]++;
        run[c] = (s_m != m_lvl[c]) ? run[c] + 1 : 0;
        if (run[c] == deb_of(c)) begin
          run[c] = 0;
          m_lvl[c] = ~m_lvl[c];
          m_rise[c] = m_lvl[c];
          m_fall[c] = ~m_lvl[c];
          age[c] = 0;
        end else if (m_lvl[c] && hold_of(c) > 0 && age[c] == hold_of(c)) begin
          m_hold[c] = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cmp_level_a", 32'(ifa.level), 32'(m_lvl[3:0]));
    chk("cmp_rise_a",  32'(ifa.rise),  32'(m_rise[3:0]));
    chk("cmp_fall_a",  32'(ifa.fall),  32'(m_fall[3:0]));
    chk("cmp_hold_a",  32'(ifa.hold),  32'(m_hold[3:0]));
    chk("cmp_level_b", 32'(ifb.level), 32'(m_lvl[4]));
    chk("cmp_rise_b",  32'(ifb.rise),  32'(m_rise[4]));
    chk("cmp_fall_b",  32'(ifb.fall),  32'(m_fall[4]));
    chk("cmp_hold_b",  32'(ifb.hold),  32'(1'b0));
  end

  task automatic drive(input int c, input logic v);
    @(negedge clk); #1 din[c] = v;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ifb.level, ifb.rise, ifb.fall, ifb.hold,
                ifa.level, ifa.rise, ifa.fall, ifa.hold});
  endfunction

  logic [4:0] bpat;
  int pulses;
  int rem[NT];

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // clean press on ch0: rise after edge 6, hold 10 edges later, fall 6 after release
    drive(0, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("press_no_early_rise", 32'(ifa.rise), 32'h0);
    @(posedge clk); #1 chk("press_rise_edge6", 32'(ifa.rise), 32'h1);
    chk("press_level", 32'(ifa.level[0]), 32'h1);
    repeat (9) @(posedge clk);
    #1 chk("hold_not_early", 32'(ifa.hold[0]), 32'h0);
    @(posedge clk); #1 chk("hold_at_10", 32'(ifa.hold), 32'h1);
    @(posedge clk); #1 chk("hold_once", 32'(ifa.hold[0]), 32'h0);
    drive(0, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("release_no_early_fall", 32'(ifa.fall[0]), 32'h0);
    @(posedge clk); #1 chk("release_fall_edge6", 32'(ifa.fall), 32'h1);
    chk("release_level", 32'(ifa.level[0]), 32'h0);
    repeat (4) @(negedge clk);

    // bounce on ch1: 1,0,1,1,0 then steady 1
    bpat = 5'b01101; // applied LSB first
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, bpat[k]);
      @(posedge clk); #1 pulses += int'(ifa.rise[1]) + int'(ifa.fall[1]);
    end
    drive(1, 1'b1);
    repeat (5) begin
      @(posedge clk); #1 pulses += int'(ifa.rise[1]) + int'(ifa.fall[1]);
    end
    chk("bounce_no_pulse", 32'(pulses), 32'h0);
    @(posedge clk); #1 chk("bounce_rise_edge6", 32'(ifa.rise), 32'h2);
    drive(1, 1'b0);
    repeat (10) @(negedge clk);

    // simultaneous rise on ch0 and ch3
    @(negedge clk); #1 begin din[0] = 1'b1; din[3] = 1'b1; end
    repeat (5) @(posedge clk);
    @(posedge clk); #1 chk("multi_rise_1001", 32'(ifa.rise), 32'h9);
    drive(0, 1'b0);
    repeat (8) @(negedge clk);

    // debounce of 1 on DUT B: single-cycle input pulse
    drive(4, 1'b1);
    drive(4, 1'b0);
    @(posedge clk); // edge 2
    @(posedge clk); #1 chk("d1_rise_edge3", 32'({ifb.rise, ifb.level}), 32'h3);
    @(posedge clk); #1 chk("d1_fall_edge4", 32'({ifb.fall, ifb.level}), 32'h2);
    repeat (4) @(negedge clk);

    // reset while ch2 is mid-debounce; ch3 held high throughout
    drive(2, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 32'h0);
    din[2] = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("post_reset_no_early", 32'(ifa.rise), 32'h0);
    @(posedge clk); #1 chk("post_reset_rise_ch3", 32'(ifa.rise), 32'h8);
    drive(3, 1'b0);
    repeat (10) @(negedge clk);

    // randomized phase: mixed bounces and long presses, one async reset
    for (int c = 0; c < NT; c++) rem[c] = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk); #1;
      for (int c = 0; c < NT; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          din[c] = ~din[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30))
                                               : int'($urandom_range(1, 5));
        end
      end
      if (cyc == 2000) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_async_reset", all_outs(), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
